restricted_mov_seq_gen: RTL and testbench
=========================================

Name: restricted_mov_seq_gen

Overview:
- Self-contained random move-sequence source: a 32-bit xorshift PRNG plus a combinational mapper.
- Each cycle, the mapper turns 13 PRNG bits into four 2-bit direction codes.
- No code equals the forbidden direction, and consecutive moves never reverse.
- Feeds game/test logic that needs a pseudo-random 4-step path with tunable straightness.

Parameters:
- SEED, 32'h92D68CA2, PRNG state loaded on reset; must be non-zero.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- restricted  input  2  forbidden direction code (0..3)
- prob  input  3  repeat-previous-move threshold; repeat chance = prob/8
- rnd_out  output  32  current PRNG state
- out_seq  output  8  {seq1,seq2,seq3,seq4}; seq1 = [7:6], seq4 = [1:0]

Behaviour:
- Single clock domain (clk). Reset is asynchronous and active-high.
- PRNG state register s[31:0]:
  - rst=1 forces s=SEED immediately, independent of clk; held while rst is high.
  - On each rising clk edge with rst=0, s advances by three steps in order:
    - t = s ^ (s<<13)
    - t = t ^ (t>>17), logical shift
    - s_next = t ^ (t<<5)
  - All shifts are 32-bit and truncate.
- rnd_out = s. Reset value is 32'h92D68CA2. A non-zero state never becomes zero.
- Mapper (purely combinational, zero latency) uses r = s[12:0]. r[1:0] are unused.
- seq1:
  - Allowed list = the three codes != restricted, in ascending order.
  - idx = r[12:11]; idx 3 maps to 0.
  - seq1 = allowed[idx].
- seq2, seq3, seq4 use 3-bit fields a = r[10:8], r[7:5], r[4:2] respectively. prev = the preceding seq value.
  - If a < prob (unsigned): repeat, so seq = prev.
  - Otherwise turn. Candidate is (prev+1) mod 4 if a[0]=0, or (prev+3) mod 4 if a[0]=1.
  - If the candidate equals restricted, use the other turn instead. Both turns cannot equal restricted.
- Invariants:
  - No seq ever equals restricted.
  - No seq ever equals (prev+2) mod 4.
- Boundary cases:
  - prob=0: every slot turns.
  - prob=7: a field of 7 still turns.
  - prob is 3-bit, so "always repeat" is impossible.
- Mid-cycle changes to restricted or prob reflect on out_seq immediately, with no registered state affected.
- During reset, out_seq is valid and derived from SEED.

Test Plan:
- Hold rst=1, restricted=0, prob=7 -> rnd_out=32'h92D68CA2, out_seq=8'hAA.
  - r=0x0CA2: idx=1, a=4,5,0, all repeats.
- Hold rst=1, restricted=0, prob=0 -> out_seq=8'hBB (2,3,2,3).
- Hold rst=1, restricted=3, prob=0 -> out_seq=8'h66 (1,2,1,2).
- Hold rst=1, restricted=2, prob=0 -> out_seq=8'h4C (1,0,3,0).
  - Exercises the redirect: slot2 candidate 2 is forbidden, so the other turn gives 0.
- Release rst and run 90 clocks with restricted=0, prob=7:
  - rnd_out matches the xorshift32 reference model every cycle and never reaches 0.
  - out_seq matches the mapper model, no seq equals 0, and no reversal occurs.
- Assert rst asynchronously between clock edges mid-run -> rnd_out returns to 32'h92D68CA2 without waiting for an edge.
  - Then sweep all restricted (0..3) x prob (0..7) over 200 cycles: model match, plus invariants hold.

Source files
------------

// File: rtl/restricted_mov_seq_gen_if.sv
// ----------------------------------------------------------------------------
// restricted_mov_seq_gen_if
// Groups the control inputs and generated outputs of the move-sequence source.
//   restricted [1:0]  forbidden direction code, driven by the consumer
//   prob       [2:0]  repeat-previous-move threshold, driven by the consumer
//   rnd_out    [31:0] current PRNG state, driven by the generator
//   out_seq    [7:0]  {seq1,seq2,seq3,seq4}, driven by the generator
// master = consumer side (drives restricted/prob); slave = generator side.
// ----------------------------------------------------------------------------
interface restricted_mov_seq_gen_if;
    logic [1:0]  restricted;
    logic [2:0]  prob;
    logic [31:0] rnd_out;
    logic [7:0]  out_seq;

    modport master (
        output restricted,
        output prob,
        input  rnd_out,
        input  out_seq
    );

    modport slave (
        input  restricted,
        input  prob,
        output rnd_out,
        output out_seq
    );
endinterface

// File: rtl/restricted_mov_seq_gen.sv
// ----------------------------------------------------------------------------
// restricted_mov_seq_gen
// Pseudo-random 4-step move source: a 32-bit xorshift PRNG advanced every
// clock, plus a zero-latency mapper turning 13 PRNG bits into four 2-bit
// direction codes that never hit the forbidden code and never reverse.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset, loads SEED into the PRNG
//   bus  slave modport: restricted/prob in, rnd_out/out_seq out
// Parameter SEED must be non-zero (xorshift keeps a zero state at zero).
// ----------------------------------------------------------------------------
module restricted_mov_seq_gen #(
    parameter logic [31:0] SEED = 32'h92D68CA2
) (
    input  logic                      clk,
    input  logic                      rst,
    restricted_mov_seq_gen_if.slave   bus
);

    logic [31:0] s_reg;
    logic [31:0] s_next;
    logic [31:0] t_a;
    logic [31:0] t_b;

    // xorshift32 (13, 17, 5); shifts are logical and truncate to 32 bits
    always_comb begin
        t_a    = s_reg ^ (s_reg << 13);
        t_b    = t_a ^ (t_a >> 17);
        s_next = t_b ^ (t_b << 5);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_reg <= SEED;
        end else begin
            s_reg <= s_next;
        end
    end

    assign bus.rnd_out = s_reg;

    // First move: pick among the three codes that are not forbidden.
    // Index 3 folds onto 0, so allowed[0] is twice as likely.
    logic [1:0] idx;
    logic [1:0] seq1;

    assign idx  = (s_reg[12:11] == 2'd3) ? 2'd0 : s_reg[12:11];
    // allowed[k] in ascending order is k when below the forbidden code,
    // otherwise k+1 (skipping the forbidden one)
    assign seq1 = (idx < bus.restricted) ? idx : idx + 2'd1;

    // Moves 2..4 each consume a 3-bit field: [10:8], [7:5], [4:2].
    // A field below prob repeats the previous move; otherwise the move turns
    // by +1 (even field) or +3 (odd field), taking the opposite turn if the
    // preferred one is forbidden. Turning never yields prev+2, and the two
    // turns differ, so at most one of them can be forbidden.
    genvar gi;
    generate
        for (gi = 1; gi < 4; gi++) begin : g_slot
            localparam int HI = 13 - 3 * gi;
            logic [2:0] a;
            logic [1:0] prev;
            logic [1:0] turn_cw;
            logic [1:0] turn_ccw;
            logic [1:0] pref;
            logic [1:0] alt;
            logic [1:0] cur;

            if (gi == 1) begin : g_first
                assign prev = seq1;
            end else begin : g_chain
                assign prev = g_slot[gi-1].cur;
            end

            assign a        = s_reg[HI -: 3];
            assign turn_cw  = prev + 2'd1;
            assign turn_ccw = prev + 2'd3;
            assign pref     = a[0] ? turn_ccw : turn_cw;
            assign alt      = a[0] ? turn_cw  : turn_ccw;
            assign cur      = (a < bus.prob) ? prev
                            : ((pref == bus.restricted) ? alt : pref);
        end
    endgenerate

    assign bus.out_seq = {seq1, g_slot[1].cur, g_slot[2].cur, g_slot[3].cur};

endmodule

// File: tb/tb_restricted_mov_seq_gen.sv
// ----------------------------------------------------------------------------
// tb_restricted_mov_seq_gen
// Self-checking bench for restricted_mov_seq_gen. A behavioural model of the
// xorshift sequence and of the move-selection rules produces every expected
// value; each transaction prints one line.
// ----------------------------------------------------------------------------
module tb_restricted_mov_seq_gen;

    localparam logic [31:0] SEED = 32'h92D68CA2;

    logic clk;
    logic rst;

    restricted_mov_seq_gen_if sif ();

    restricted_mov_seq_gen #(.SEED(SEED)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          pass_cnt  = 0;
    int          total_cnt = 0;
    logic [31:0] model_s;

    function automatic logic [31:0] ref_step(input logic [31:0] st);
        logic [31:0] t;
        t = st ^ (st << 13);
        t = t ^ (t >> 17);
        return t ^ (t << 5);
    endfunction

    // Move rules written directly from the behaviour description.
    function automatic logic [7:0] ref_map(input logic [31:0] st, input int res, input int pr);
        int allowed[$];
        int mv[4];
        int k_idx;
        int a;
        int pref;
        int alt;
        for (int d = 0; d < 4; d++)
            if (d != res) allowed.push_back(d);
        k_idx = int'((st >> 11) & 32'd3);
        if (k_idx == 3) k_idx = 0;
        mv[0] = allowed[k_idx];
        for (int k = 1; k < 4; k++) begin
            a = int'((st >> (11 - 3 * k)) & 32'd7);
            if (a < pr) begin
                mv[k] = mv[k-1];
            end else begin
                pref  = (a % 2 == 0) ? (mv[k-1] + 1) % 4 : (mv[k-1] + 3) % 4;
                alt   = (a % 2 == 0) ? (mv[k-1] + 3) % 4 : (mv[k-1] + 1) % 4;
                mv[k] = (pref == res) ? alt : pref;
            end
        end
        return {2'(mv[0]), 2'(mv[1]), 2'(mv[2]), 2'(mv[3])};
    endfunction

    // Compares current outputs with the model and checks invariants.
    // Called from the scenario tasks; every comparison is inline here.
    task automatic check_now(input string tag);
        logic [7:0] exp_seq;
        logic [1:0] mv [4];
        int         res;
        res     = int'(sif.restricted);
        exp_seq = ref_map(model_s, res, int'(sif.prob));
        $display("%s: res=%0d prob=%0d rnd_out=%08h out_seq=%02h exp_rnd=%08h exp_seq=%02h",
                 tag, sif.restricted, sif.prob, sif.rnd_out, sif.out_seq, model_s, exp_seq);
        total_cnt++;
        if (sif.rnd_out !== model_s)
            $display("FAIL %s rnd_out: got %08h expected %08h", tag, sif.rnd_out, model_s);
        else pass_cnt++;
        total_cnt++;
        if (sif.rnd_out === 32'd0)
            $display("FAIL %s rnd_nonzero: got %08h expected non-zero", tag, sif.rnd_out);
        else pass_cnt++;
        total_cnt++;
        if (sif.out_seq !== exp_seq)
            $display("FAIL %s out_seq: got %02h expected %02h", tag, sif.out_seq, exp_seq);
        else pass_cnt++;
        mv[0] = sif.out_seq[7:6];
        mv[1] = sif.out_seq[5:4];
        mv[2] = sif.out_seq[3:2];
        mv[3] = sif.out_seq[1:0];
        for (int k = 0; k < 4; k++) begin
            total_cnt++;
            if (int'(mv[k]) == res)
                $display("FAIL %s forbidden slot%0d: got %0d expected not %0d", tag, k + 1, mv[k], res);
            else pass_cnt++;
            if (k > 0) begin
                total_cnt++;
                if (int'(mv[k]) == (int'(mv[k-1]) + 2) % 4)
                    $display("FAIL %s reversal slot%0d: got %0d after %0d expected no reversal",
                             tag, k + 1, mv[k], mv[k-1]);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_reset();
        logic [7:0] exp_tab [4];
        logic [1:0] res_tab [4];
        logic [2:0] prob_tab [4];
        exp_tab  = '{8'hAA, 8'hBB, 8'h66, 8'h4C};
        res_tab  = '{2'd0, 2'd0, 2'd3, 2'd2};
        prob_tab = '{3'd7, 3'd0, 3'd0, 3'd0};
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_s = SEED;
        for (int i = 0; i < 4; i++) begin
            sif.restricted = res_tab[i];
            sif.prob       = prob_tab[i];
            #1;
            $display("reset[%0d]: res=%0d prob=%0d rnd_out=%08h out_seq=%02h",
                     i, sif.restricted, sif.prob, sif.rnd_out, sif.out_seq);
            total_cnt++;
            if (sif.rnd_out !== SEED)
                $display("FAIL reset_rnd[%0d]: got %08h expected %08h", i, sif.rnd_out, SEED);
            else pass_cnt++;
            total_cnt++;
            if (sif.out_seq !== exp_tab[i])
                $display("FAIL reset_seq[%0d]: got %02h expected %02h", i, sif.out_seq, exp_tab[i]);
            else pass_cnt++;
            check_now("reset_model");
        end
        // reset held across an edge keeps SEED
        @(posedge clk);
        #1;
        check_now("reset_hold");
    endtask

    task automatic test_run(input int cycles);
        sif.restricted = 2'd0;
        sif.prob       = 3'd7;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            model_s = ref_step(model_s);
            check_now("run");
        end
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #1;
        model_s = ref_step(model_s);
        #2;
        rst = 1'b1;
        #1;
        model_s = SEED;
        // still well before the next rising edge
        $display("async_reset: rnd_out=%08h", sif.rnd_out);
        total_cnt++;
        if (sif.rnd_out !== SEED)
            $display("FAIL async_reset: got %08h expected %08h", sif.rnd_out, SEED);
        else pass_cnt++;
        check_now("async_reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_sweep(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            model_s        = ref_step(model_s);
            sif.restricted = 2'(c % 4);
            sif.prob       = 3'((c / 4) % 8);
            #1;
            check_now("sweep");
        end
    endtask

    task automatic test_random_midcycle(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            model_s        = ref_step(model_s);
            sif.restricted = 2'($urandom_range(0, 3));
            sif.prob       = 3'($urandom_range(0, 7));
            #1;
            check_now("random");
            // change inputs between edges: outputs follow, state does not move
            sif.restricted = 2'($urandom_range(0, 3));
            sif.prob       = 3'($urandom_range(0, 7));
            #1;
            check_now("midcycle");
        end
    endtask

    initial begin
        rst            = 1'b1;
        sif.restricted = 2'd0;
        sif.prob       = 3'd7;
        model_s        = SEED;
        test_reset();
        test_run(90);
        test_async_reset();
        test_sweep(200);
        test_random_midcycle(60);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
